// File: rtl/bcd_display_ctrl.sv
// Double-dabble binary-to-BCD converter driving a 4-digit multiplexed 7-seg display.
// Optional: define BCD_BLANK_LZ_EN to blank leading zeros on digits 3..1.
module bcd_display_ctrl #(
    parameter int BIN_W       = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             load,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd_out,
    output logic             ovf,
    output logic [3:0]       an,
    output logic [6:0]       seg
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [BIN_W-1:0] DEC_MAX = BIN_W'(9999);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q;
    logic [BIN_W-1:0] sreg_q;
    logic [15:0]      scratch_q;
    logic [3:0]       step_q;
    logic             ovf_n_q;
    logic             busy_q;
    logic             done_q;
    logic [15:0]      bcd_q;
    logic             ovf_q;

    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       idx_q;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;

    logic [15:0]      adj_d;
    logic [3:0]       digit_d;
    logic             blank_d;
    logic [6:0]       seg_d;

    // Add-3 correction on every scratch nibble that will reach >=10 after the shift
    always_comb begin
        adj_d = scratch_q;
        for (int i = 0; i < 4; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj_d[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM with registered handshake and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            scratch_q <= '0;
            step_q    <= '0;
            ovf_n_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q   <= SHIFT;
                        busy_q    <= 1'b1;
                        sreg_q    <= bin_in;
                        scratch_q <= '0;
                        step_q    <= '0;
                        ovf_n_q   <= (bin_in > DEC_MAX);
                    end
                end
                SHIFT: begin
                    scratch_q <= {adj_d[14:0], sreg_q[BIN_W-1]};
                    sreg_q    <= sreg_q << 1;
                    step_q    <= step_q + 4'd1;
                    if (step_q == 4'(BIN_W - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    bcd_q  <= ovf_n_q ? 16'h9999 : scratch_q;
                    ovf_q  <= ovf_n_q;
                    done_q <= 1'b1;
                    // busy is already low here, so a request is honoured
                    if (load) begin
                        state_q   <= SHIFT;
                        busy_q    <= 1'b1;
                        sreg_q    <= bin_in;
                        scratch_q <= '0;
                        step_q    <= '0;
                        ovf_n_q   <= (bin_in > DEC_MAX);
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Free-running refresh counter; digit index advances on wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
            idx_q <= idx_q + 2'd1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Select the scanned digit and decide whether it is a blanked leading zero
    always_comb begin
        digit_d = bcd_q[4*idx_q +: 4];
        blank_d = 1'b0;
`ifdef BCD_BLANK_LZ_EN
        unique case (idx_q)
            2'd3:    blank_d = (bcd_q[15:12] == 4'd0);
            2'd2:    blank_d = (bcd_q[15:8] == 8'd0);
            2'd1:    blank_d = (bcd_q[15:4] == 12'd0);
            default: blank_d = 1'b0;
        endcase
`endif
    end

    // Active-low segment decode {g,f,e,d,c,b,a}; non-decimal nibbles blank
    always_comb begin
        seg_d = 7'b1111111;
        if (!blank_d) begin
            unique case (digit_d)
                4'd0:    seg_d = 7'b1000000;
                4'd1:    seg_d = 7'b1111001;
                4'd2:    seg_d = 7'b0100100;
                4'd3:    seg_d = 7'b0110000;
                4'd4:    seg_d = 7'b0011001;
                4'd5:    seg_d = 7'b0010010;
                4'd6:    seg_d = 7'b0000010;
                4'd7:    seg_d = 7'b1111000;
                4'd8:    seg_d = 7'b0000000;
                4'd9:    seg_d = 7'b0010000;
                default: seg_d = 7'b1111111;
            endcase
        end
    end

    // Register display pins one edge after the digit index moves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= 4'b1110;
            seg_q <= 7'b1000000;
        end else begin
            an_q  <= ~(4'b0001 << idx_q);
            seg_q <= seg_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;
    assign an      = an_q;
    assign seg     = seg_q;

endmodule
